mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single memory/IO port (RW/en/MemIO/addr/data_write/data_read bus) between two requesters.
//   Port F is instruction fetch; port D is the data access stage (LDA/STA/IN/OUT).
//   Sequences each transfer with a req/ack handshake and a programmable number of wait cycles.
//   Sits between the pipeline stages and the memory/IO export block.
// PARAMETERS
//   AW        16  address width
//   DW        16  data width
//   WAIT_CYC  1   cycles bus_en is held before bus_rdata is sampled (must be >= 1)
//   RR_MODE   0   0: fixed priority, D beats F; 1: round-robin on simultaneous requests
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   reset, asynchronous, active-high
//   f_req      in   1   fetch request; level, held until f_ack
//   f_rw       in   1   0=read, 1=write
//   f_memio    in   1   0=memory, 1=IO
//   f_addr     in   AW  address
//   f_wdata    in   DW  write data
//   f_ack      out  1   one-cycle completion pulse
//   f_rdata    out  DW  read data, valid while f_ack=1, held afterwards
//   d_req/d_rw/d_memio/d_addr/d_wdata/d_ack/d_rdata  same as the f_* ports, for the data port
//   bus_en     out  1   bus enable
//   bus_rw     out  1   0=R, 1=W
//   bus_memio  out  1   0=mem, 1=IO
//   bus_addr   out  AW  address; IO cycles drive {0, addr[7:0]}
//   bus_wdata  out  DW  write data
//   bus_rdata  in   DW  read data from the memory/IO block
//   busy       out  1   1 in ACCESS or DONE
// BEHAVIOUR
//   - All outputs are registered. Reset clears every output, f_rdata, d_rdata, cnt, state=IDLE and last_gnt=D.
//   - FSM states are IDLE, ACCESS and DONE.
//   - IDLE:
//     - When any req=1 at an edge: select a winner, latch its rw/memio/addr/wdata onto bus_*, set bus_en=1.
//     - Load cnt=WAIT_CYC-1, record the winner in gnt, then go to ACCESS.
//     - When no req is high: stay in IDLE with bus_en=0.
//   - Arbitration on simultaneous requests:
//     - RR_MODE=0: D wins.
//     - RR_MODE=1: the port that is not last_gnt wins. After reset, F therefore wins the first tie.
//     - A single requester always wins. last_gnt is updated on every grant.
//   - ACCESS:
//     - bus_* are held stable. When cnt!=0, decrement cnt.
//     - When cnt==0:
//       - On a read, capture bus_rdata into the winner's rdata.
//       - Assert the winner's ack, drop bus_en, go to DONE.
//   - DONE:
//     - ack is high for exactly this one cycle; bus_en=0. Next state is always IDLE.
//   - Latency: req first seen at edge 0. bus_en is high for cycles 1..WAIT_CYC; ack is high in cycle WAIT_CYC+1.
//   - Back-to-back: the earliest next grant is at the edge leaving DONE+IDLE, which leaves at least one idle bus cycle between transfers.
//   - Requesters deassert req at the edge on which they see ack=1. A req still high in IDLE is a new transfer.
//   - The loser keeps its req high and is granted after the current transfer completes. It is never dropped.
//   - A req deasserted mid-transfer does not abort: the transfer completes and ack still pulses.
//   - Write transfers leave rdata unchanged. The non-granted port's rdata is never modified.
//   - IO addressing: bus_addr = {(AW-8)'b0, addr[7:0]} when memio=1.
//   - Reset mid-transfer: bus_en drops immediately (asynchronously), no ack is issued, and the FSM returns to IDLE.
// TESTING
//   - F read only: WAIT_CYC=1, f_req=1, f_addr=0x0010, bus_rdata=0xBEEF -> bus_en high 1 cycle, then f_ack=1 with f_rdata=0xBEEF.
//   - D write to IO: d_memio=1, d_addr=0x12AB, d_wdata=0x005A -> bus_addr=0x00AB, bus_rw=1, bus_wdata=0x005A; d_ack pulses; d_rdata unchanged.
//   - Tie, RR_MODE=0: f_req and d_req rise in the same cycle -> D served first, then F; the two acks are separated by WAIT_CYC+2 cycles.
//   - Tie, RR_MODE=1: three consecutive simultaneous ties -> grant order F, D, F.
//   - WAIT_CYC=3 read: bus_en high exactly 3 cycles; ack in cycle 4; bus_rdata changed during cycles 1-2 is ignored and the value at cycle 3 is captured.
//   - Assert rst during ACCESS -> bus_en=0 in the same cycle; no ack; state IDLE; a new req after reset completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory/IO bus between a fetch port (F) and a data port (D) with req/ack handshakes and a fixed wait count
//   clk, rst                          clock (rising edge), asynchronous active-high reset
//   f_req/f_rw/f_memio/f_addr/f_wdata fetch request; level, held until f_ack
//   f_ack, f_rdata                    one-cycle completion pulse, read data held after ack
//   d_*                               same as f_*, for the data port
//   bus_en/bus_rw/bus_memio           registered bus strobes (rw: 0=R 1=W, memio: 0=mem 1=IO)
//   bus_addr/bus_wdata                registered bus address (IO cycles use addr[7:0]) and write data
//   bus_rdata                         read data returned by the memory/IO block
//   busy                              high while a transfer is in ACCESS or DONE
module mem_bus_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int WAIT_CYC = 1,
   parameter int RR_MODE  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic          f_rw,
   input  logic          f_memio,
   input  logic [AW-1:0] f_addr,
   input  logic [DW-1:0] f_wdata,
   output logic          f_ack,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_rw,
   input  logic          d_memio,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          bus_en,
   output logic          bus_rw,
   output logic          bus_memio,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          last_gnt, last_gnt_n;
   logic          win_d, s_rw, s_memio;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic          bus_en_n, bus_rw_n, bus_memio_n, f_ack_n, d_ack_n, busy_n;
   logic [AW-1:0] bus_addr_n;
   logic [DW-1:0] bus_wdata_n, f_rdata_n, d_rdata_n;
   // last_gnt=1 means D; it also names the owner of the transfer in flight
   assign win_d   = d_req & (~f_req | (RR_MODE == 0) | ~last_gnt);
   assign s_rw    = win_d ? d_rw : f_rw;
   assign s_memio = win_d ? d_memio : f_memio;
   assign s_addr  = win_d ? d_addr : f_addr;
   assign s_wdata = win_d ? d_wdata : f_wdata;
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      last_gnt_n  = last_gnt;
      bus_en_n    = bus_en;
      bus_rw_n    = bus_rw;
      bus_memio_n = bus_memio;
      bus_addr_n  = bus_addr;
      bus_wdata_n = bus_wdata;
      f_ack_n     = 1'b0;
      d_ack_n     = 1'b0;
      f_rdata_n   = f_rdata;
      d_rdata_n   = d_rdata;
      unique case (state)
         IDLE: if (f_req | d_req) begin
            bus_en_n    = 1'b1;
            bus_rw_n    = s_rw;
            bus_memio_n = s_memio;
            bus_addr_n  = s_memio ? {{(AW-8){1'b0}}, s_addr[7:0]} : s_addr;
            bus_wdata_n = s_wdata;
            cnt_n       = CW'(WAIT_CYC - 1);
            last_gnt_n  = win_d;
            state_n     = ACCESS;
         end
         ACCESS: if (cnt != '0) cnt_n = cnt - 1'b1;
         else begin
            f_ack_n   = ~last_gnt;
            d_ack_n   = last_gnt;
            f_rdata_n = (!bus_rw && !last_gnt) ? bus_rdata : f_rdata;
            d_rdata_n = (!bus_rw && last_gnt) ? bus_rdata : d_rdata;
            bus_en_n  = 1'b0;
            state_n   = DONE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last_gnt  <= 1'b1;
         bus_en    <= 1'b0;
         bus_rw    <= 1'b0;
         bus_memio <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         last_gnt  <= last_gnt_n;
         bus_en    <= bus_en_n;
         bus_rw    <= bus_rw_n;
         bus_memio <= bus_memio_n;
         bus_addr  <= bus_addr_n;
         bus_wdata <= bus_wdata_n;
         f_ack     <= f_ack_n;
         d_ack     <= d_ack_n;
         f_rdata   <= f_rdata_n;
         d_rdata   <= d_rdata_n;
         busy      <= busy_n;
      end
endmodule
